// File: rtl/hex_key_encoder_pkg.sv
// Shared types, default timing constants and a counter-width helper for the
// hex key encoder and its debouncer.
package hex_key_encoder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int DEFAULT_HOLDOFF_CYCLES  = 10000000;

   // Bits needed for a counter holding values 0..n-1 (never less than one bit)
   function automatic int cnt_width(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/hex_key_encoder_tick_debouncer.sv
// Synchronizes an N-bit raw input vector, samples it on a slow tick and only
// accepts a bit once two consecutive tick samples agree. The first accept
// after reset waits for the whole vector to be stable and loads it silently.
module tick_debouncer
   import hex_key_encoder_pkg::*;
#(
   parameter int N               = 17,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] din,
   output logic [N-1:0] db,
   output logic         changed
);

   localparam int TW = cnt_width(DEBOUNCE_CYCLES);

   logic [N-1:0]  sync1;
   logic [N-1:0]  sync2;
   logic [N-1:0]  sample;
   logic [N-1:0]  stable;
   logic [N-1:0]  accepted;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          init;

   // The incoming synced value becomes the new sample and the current sample
   // becomes the previous one, so a bit is stable when those two agree.
   assign tick     = (tick_cnt == TW'(DEBOUNCE_CYCLES - 1));
   assign stable   = ~(sync2 ^ sample);
   assign accepted = (db & ~stable) | (sync2 & stable);

   // Two-flop synchronizer for every raw input bit
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Free-running sample-tick counter that wraps every DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Tick sampling, stability acceptance, silent initial load and change strobe
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sample  <= '0;
         db      <= '0;
         init    <= 1'b1;
         changed <= 1'b0;
      end else begin
         changed <= 1'b0;
         if (tick) begin
            sample <= sync2;
            if (init) begin
               if (&stable) begin
                  db   <= sync2;
                  init <= 1'b0;
               end
            end else begin
               db      <= accepted;
               changed <= (accepted != db);
            end
         end
      end
   end

endmodule

// File: rtl/hex_key_encoder.sv
// Turns 16 hex switches and a delete button into spaced single-cycle add/del
// pulses. Debounced edges are queued as pending bits and served one at a time,
// lowest switch index first and delete last, with a holdoff between pulses.
module hex_key_encoder
   import hex_key_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int HOLDOFF_CYCLES  = DEFAULT_HOLDOFF_CYCLES
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] sw,
   input  logic        del_btn,
   output logic [3:0]  hex,
   output logic        add,
   output logic        del,
   output logic        busy
);

   localparam int HW = cnt_width(HOLDOFF_CYCLES);

   logic [16:0]   db;
   logic [16:0]   db_q;
   logic          db_changed;
   logic [15:0]   sw_ev;
   logic          del_ev;
   logic [15:0]   pend_sw;
   logic          pend_del;
   logic [HW-1:0] hold_cnt;
   logic          hold_done;
   state_t        state;
   state_t        state_next;
   logic          issue_add;
   logic          issue_del;
   logic [3:0]    sel_idx;
   logic [15:0]   clr_mask;

   tick_debouncer #(
      .N               (17),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk     (clk),
      .rstn    (rstn),
      .din     ({del_btn, sw}),
      .db      (db),
      .changed (db_changed)
   );

   // db_q lags db by one cycle, so during the change strobe it holds the old value
   assign sw_ev     = db_changed ? (db[15:0] ^ db_q[15:0]) : 16'h0000;
   assign del_ev    = db_changed & db[16] & ~db_q[16];
   assign hold_done = (hold_cnt == HW'(HOLDOFF_CYCLES - 2));
   assign busy      = (state == HOLD) || (pend_sw != 16'h0000) || pend_del;

   // Previous debounced vector for edge detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         db_q <= '0;
      end else begin
         db_q <= db;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state: leave IDLE on any pending event, leave HOLD when holdoff expires
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if ((pend_sw != 16'h0000) || pend_del) state_next = HOLD;
         HOLD: if (hold_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: pick the lowest pending switch, otherwise a pending delete
   always_comb begin
      issue_add = 1'b0;
      issue_del = 1'b0;
      sel_idx   = 4'h0;
      clr_mask  = 16'h0000;
      for (int i = 15; i >= 0; i--) begin
         if (pend_sw[i]) sel_idx = 4'(i);
      end
      if (state == IDLE) begin
         if (pend_sw != 16'h0000) begin
            issue_add = 1'b1;
            clr_mask  = 16'h0001 << sel_idx;
         end else if (pend_del) begin
            issue_del = 1'b1;
         end
      end
   end

   // Holdoff counter runs only while in HOLD and restarts from zero in IDLE
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_cnt <= '0;
      end else if (state == HOLD) begin
         hold_cnt <= hold_cnt + 1'b1;
      end else begin
         hold_cnt <= '0;
      end
   end

   // Pending bits (a new event wins over a same-cycle clear) and registered pulses
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_sw  <= '0;
         pend_del <= 1'b0;
         add      <= 1'b0;
         del      <= 1'b0;
         hex      <= 4'h0;
      end else begin
         pend_sw  <= (pend_sw & ~clr_mask) | sw_ev;
         pend_del <= (pend_del & ~issue_del) | del_ev;
         add      <= issue_add;
         del      <= issue_del;
         if (issue_add) hex <= sel_idx;
      end
   end

endmodule

// File: tb/tb_hex_key_encoder.sv
// Directed bench for hex_key_encoder with short debounce and holdoff periods.
// Stimulus pushes expected pulses into a queue; a monitor pops and compares
// every add/del pulse the design produces.
module tb_hex_key_encoder;

   localparam int DEB  = 4;
   localparam int HOLD = 8;

   typedef struct {
      bit         is_del;
      logic [3:0] code;
      int         gap;
   } exp_t;

   logic        clk     = 1'b0;
   logic        rstn    = 1'b0;
   logic [15:0] sw      = 16'h0005;
   logic        del_btn = 1'b0;
   logic [3:0]  hex;
   logic        add;
   logic        del;
   logic        busy;

   exp_t        exp_q[$];
   exp_t        mon_entry;
   int          n_vectors       = 0;
   int          n_miscompares   = 0;
   int          cycle_count     = 0;
   int          last_pulse      = -1000;
   logic [3:0]  prev_hex        = 4'h0;
   bit          seen;

   hex_key_encoder #(
      .DEBOUNCE_CYCLES (DEB),
      .HOLDOFF_CYCLES  (HOLD)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .sw      (sw),
      .del_btn (del_btn),
      .hex     (hex),
      .add     (add),
      .del     (del),
      .busy    (busy)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] new_sw, input logic new_del);
      @(posedge clk);
      #1;
      sw      = new_sw;
      del_btn = new_del;
   endtask

   task automatic expectPulse(input bit is_del, input logic [3:0] code, input int gap);
      exp_t e;
      e.is_del = is_del;
      e.code   = code;
      e.gap    = gap;
      exp_q.push_back(e);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic waitDrain(input string name, input int max_cycles);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_miscompares++;
         $display("[TB] FAIL %s: %0d pulses outstanding after %0d cycles, expected 0", name, exp_q.size(), max_cycles);
         exp_q.delete();
      end
   endtask

   task automatic waitAdd(input int max_cycles, output bit got);
      got = 1'b0;
      for (int n = 0; n < max_cycles && !got; n++) begin
         @(negedge clk);
         if (add) got = 1'b1;
      end
   endtask

   // Monitor: compare every pulse against the scoreboard and watch invariants
   always @(negedge clk) begin
      cycle_count++;
      if (rstn) begin
         if (add || del) begin
            checkOutput("add_del_exclusive", {31'b0, add & del}, 32'd0);
            if (exp_q.size() == 0) begin
               n_miscompares++;
               $display("[TB] FAIL unexpected_pulse: got add=%0b del=%0b hex=%0h, expected no pulse", add, del, hex);
            end else begin
               mon_entry = exp_q.pop_front();
               checkOutput("pulse_is_del", {31'b0, del}, {31'b0, mon_entry.is_del});
               if (!mon_entry.is_del) checkOutput("pulse_hex", {28'b0, hex}, {28'b0, mon_entry.code});
               if (mon_entry.gap != 0) checkOutput("pulse_spacing", cycle_count - last_pulse, mon_entry.gap);
            end
            last_pulse = cycle_count;
         end
         if (hex !== prev_hex && !add) begin
            n_miscompares++;
            $display("[TB] FAIL hex_stable: got %0h without add, expected %0h", hex, prev_hex);
         end
      end
      prev_hex = hex;
   end

   // Directed stimulus sequence
   initial begin
      // Reset with switches 0 and 2 already up
      waitCycles(3);
      checkOutput("reset_hex",  {28'b0, hex}, 32'd0);
      checkOutput("reset_add",  {31'b0, add}, 32'd0);
      checkOutput("reset_del",  {31'b0, del}, 32'd0);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      #3 rstn = 1'b1;
      waitCycles(40);
      checkOutput("idle_hex",  {28'b0, hex}, 32'd0);
      checkOutput("idle_busy", {31'b0, busy}, 32'd0);

      // sw[10] rises: one add with hex A, busy clears after the holdoff
      expectPulse(1'b0, 4'hA, 0);
      applyStimulus(sw | 16'h0400, 1'b0);
      waitAdd(60, seen);
      checkOutput("add_a_seen", {31'b0, seen}, 32'd1);
      checkOutput("busy_at_add", {31'b0, busy}, 32'd1);
      waitCycles(HOLD);
      checkOutput("busy_after_hold", {31'b0, busy}, 32'd0);
      waitDrain("drain_a", 20);
      waitCycles(20);

      // sw[3] and sw[12] together: lower index first, then exact spacing
      expectPulse(1'b0, 4'h3, 0);
      expectPulse(1'b0, 4'hC, HOLD);
      applyStimulus(sw ^ 16'h1008, 1'b0);
      waitDrain("drain_3_c", 80);
      waitCycles(20);

      // sw[7] then delete pressed during the following HOLD
      expectPulse(1'b0, 4'h7, 0);
      expectPulse(1'b1, 4'h0, HOLD);
      applyStimulus(sw ^ 16'h0080, 1'b0);
      waitCycles(2);
      applyStimulus(sw, 1'b1);
      waitDrain("drain_7_del", 80);
      applyStimulus(sw, 1'b0);
      waitCycles(40);

      // Bouncing delete button settles high: exactly one delete
      expectPulse(1'b1, 4'h0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(sw, (i % 2) == 0);
      applyStimulus(sw, 1'b1);
      waitDrain("drain_bounce_del", 80);
      applyStimulus(sw, 1'b0);
      waitCycles(40);

      // sw[0], sw[1], sw[2] toggle; sw[2] toggles back while its event is still queued
      expectPulse(1'b0, 4'h0, 0);
      expectPulse(1'b0, 4'h1, HOLD);
      expectPulse(1'b0, 4'h2, HOLD);
      applyStimulus(sw ^ 16'h0007, 1'b0);
      waitCycles(10);
      applyStimulus(sw ^ 16'h0004, 1'b0);
      waitDrain("drain_0_1_2", 100);
      waitCycles(40);

      // Reset mid-HOLD with sw[5] still pending: outputs clear, no add for sw[5]
      expectPulse(1'b0, 4'h3, 0);
      applyStimulus(sw ^ 16'h0028, 1'b0);
      waitAdd(60, seen);
      checkOutput("add_3_seen", {31'b0, seen}, 32'd1);
      waitCycles(2);
      #3 rstn = 1'b0;
      #1;
      checkOutput("async_reset_hex",  {28'b0, hex}, 32'd0);
      checkOutput("async_reset_add",  {31'b0, add}, 32'd0);
      checkOutput("async_reset_del",  {31'b0, del}, 32'd0);
      checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
      waitCycles(3);
      #2 rstn = 1'b1;
      waitCycles(60);
      checkOutput("reinit_hex",  {28'b0, hex}, 32'd0);
      checkOutput("reinit_busy", {31'b0, busy}, 32'd0);
      waitDrain("final_drain", 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
